// File: rtl/cordic_output_restorer.sv
// cordic_output_restorer: restores CORDIC rotation results to their original quadrant.
//
// Quadrant tags are queued in order as samples enter the core. Each core result
// pops one tag and is rotated by +q*90 degrees before it is presented downstream.
//
// Optional feature macro: CORDIC_GAIN_COMP_EN
//   Defined   : a second register stage scales x and y by 1/K (19899 in Q1.15); latency 2.
//   Undefined : single register stage, latency 1; outputs still carry the CORDIC gain K.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   tag_valid/tag_ready/tag_quadrant  quadrant tag push side (tag_ready = !full)
//   res_valid/res_ready/res_x/res_y   core result side (res_ready = !empty && pipe_en)
//   out_valid/out_ready/out_x/out_y/out_quadrant  restored sample stream
//   tag_count                     number of tags currently buffered
module cordic_output_restorer #(
    parameter  int FRAC_BITS = 15,
    parameter  int TAG_DEPTH = 8,
    localparam int W         = FRAC_BITS + 1,
    localparam int AW        = $clog2(TAG_DEPTH),
    localparam int CW        = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tag_valid,
    output logic          tag_ready,
    input  logic [1:0]    tag_quadrant,
    input  logic          res_valid,
    output logic          res_ready,
    input  logic [W-1:0]  res_x,
    input  logic [W-1:0]  res_y,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_x,
    output logic [W-1:0]  out_y,
    output logic [1:0]    out_quadrant,
    output logic [CW-1:0] tag_count
);

    // Negating the most negative value would wrap; clamp it to the most positive.
    function automatic logic [W-1:0] neg_sat(input logic [W-1:0] v);
        return (v == {1'b1, {(W-1){1'b0}}}) ? {1'b0, {(W-1){1'b1}}} : -v;
    endfunction

    logic [1:0]    mem_q [TAG_DEPTH];
    logic [1:0]    mem_d [TAG_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full, empty, push, pop, pipe_en;
    logic [1:0]    q;
    logic [W-1:0]  rot_x, rot_y;

    logic          s1_valid_q, s1_valid_d;
    logic [W-1:0]  s1_x_q, s1_x_d, s1_y_q, s1_y_d;
    logic [1:0]    s1_quad_q, s1_quad_d;

    always_comb begin
        full      = (count_q == CW'(TAG_DEPTH));
        empty     = (count_q == '0);
        tag_ready = !full;
        pipe_en   = !out_valid || out_ready;
        res_ready = !empty && pipe_en;
        push      = tag_valid && tag_ready;
        pop       = res_valid && res_ready;
        wr_ptr_d  = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d   = count_q + CW'(push) - CW'(pop);
        tag_count = count_q;
        mem_d     = mem_q;
        if (push) mem_d[wr_ptr_q] = tag_quadrant;
    end

    // Counter-clockwise rotation by q quarter turns.
    always_comb begin
        q     = mem_q[rd_ptr_q];
        rot_x = (q == 2'd0) ? res_x : (q == 2'd1) ? neg_sat(res_y) :
                (q == 2'd2) ? neg_sat(res_x) : res_y;
        rot_y = (q == 2'd0) ? res_y : (q == 2'd1) ? res_x :
                (q == 2'd2) ? neg_sat(res_y) : neg_sat(res_x);
    end

    always_comb begin
        s1_valid_d = pipe_en ? pop : s1_valid_q;
        s1_x_d     = (pipe_en && pop) ? rot_x : s1_x_q;
        s1_y_d     = (pipe_en && pop) ? rot_y : s1_y_q;
        s1_quad_d  = (pipe_en && pop) ? q : s1_quad_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAG_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            s1_valid_q <= 1'b0;
            s1_x_q     <= '0;
            s1_y_q     <= '0;
            s1_quad_q  <= '0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            s1_valid_q <= s1_valid_d;
            s1_x_q     <= s1_x_d;
            s1_y_q     <= s1_y_d;
            s1_quad_q  <= s1_quad_d;
        end
    end

`ifdef CORDIC_GAIN_COMP_EN
    // Multiply by 1/K in Q1.15 with round-half-up, then keep the W-bit result.
    function automatic logic [W-1:0] gain(input logic [W-1:0] v);
        logic signed [W+16:0] p;
        p = $signed(v) * $signed(17'sd19899) + (W+17)'(16384);
        return p[W+14:15];
    endfunction

    logic          s2_valid_q, s2_valid_d;
    logic [W-1:0]  s2_x_q, s2_x_d, s2_y_q, s2_y_d;
    logic [1:0]    s2_quad_q, s2_quad_d;

    always_comb begin
        s2_valid_d = pipe_en ? s1_valid_q : s2_valid_q;
        s2_x_d     = (pipe_en && s1_valid_q) ? gain(s1_x_q) : s2_x_q;
        s2_y_d     = (pipe_en && s1_valid_q) ? gain(s1_y_q) : s2_y_q;
        s2_quad_d  = (pipe_en && s1_valid_q) ? s1_quad_q : s2_quad_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_x_q     <= '0;
            s2_y_q     <= '0;
            s2_quad_q  <= '0;
        end else begin
            s2_valid_q <= s2_valid_d;
            s2_x_q     <= s2_x_d;
            s2_y_q     <= s2_y_d;
            s2_quad_q  <= s2_quad_d;
        end
    end

    always_comb begin
        out_valid    = s2_valid_q;
        out_x        = s2_x_q;
        out_y        = s2_y_q;
        out_quadrant = s2_quad_q;
    end
`else
    always_comb begin
        out_valid    = s1_valid_q;
        out_x        = s1_x_q;
        out_y        = s1_y_q;
        out_quadrant = s1_quad_q;
    end
`endif

endmodule

// File: tb/tb_cordic_output_restorer.sv
// tb_cordic_output_restorer: directed self-checking bench for cordic_output_restorer.
module tb_cordic_output_restorer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tag_valid = 1'b0;
    logic        tag_ready;
    logic [1:0]  tag_quadrant = 2'd0;
    logic        res_valid = 1'b0;
    logic        res_ready;
    logic [15:0] res_x = '0;
    logic [15:0] res_y = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_x, out_y;
    logic [1:0]  out_quadrant;
    logic [3:0]  tag_count;
    int checks = 0;
    int errors = 0;

    cordic_output_restorer #(.FRAC_BITS(15), .TAG_DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .tag_valid(tag_valid), .tag_ready(tag_ready), .tag_quadrant(tag_quadrant),
        .res_valid(res_valid), .res_ready(res_ready), .res_x(res_x), .res_y(res_y),
        .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
        .out_quadrant(out_quadrant), .tag_count(tag_count)
    );

    always #5 clk = ~clk;

    task automatic push_tag(input logic [1:0] qd);
        @(negedge clk);
        tag_valid = 1'b1;
        tag_quadrant = qd;
        @(negedge clk);
        tag_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (tag_count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", tag_count); end
        checks++; if (tag_ready !== 1'b1) begin errors++; $display("FAIL reset_tag_ready got %b want 1", tag_ready); end
        checks++; if (res_ready !== 1'b0) begin errors++; $display("FAIL reset_res_ready got %b want 0", res_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if ({out_x, out_y, out_quadrant} !== 34'd0) begin errors++; $display("FAIL reset_out got %h %h %0d want 0 0 0", out_x, out_y, out_quadrant); end
        rst_n = 1'b1;
    endtask

    task automatic test_q0();
        push_tag(2'd0);
        @(negedge clk);
        res_valid = 1'b1; res_x = 16'h4000; res_y = 16'h2000;
        #1;
        checks++; if (res_ready !== 1'b1) begin errors++; $display("FAIL q0_res_ready got %b want 1", res_ready); end
        @(negedge clk);
        res_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL q0_valid got %b want 1", out_valid); end
        checks++; if ({out_x, out_y} !== {16'h4000, 16'h2000}) begin errors++; $display("FAIL q0_out got %h %h want 4000 2000", out_x, out_y); end
        checks++; if (out_quadrant !== 2'd0) begin errors++; $display("FAIL q0_quad got %0d want 0", out_quadrant); end
        checks++; if (tag_count !== 4'd0) begin errors++; $display("FAIL q0_count got %0d want 0", tag_count); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL q0_drop got %b want 0", out_valid); end
    endtask

    task automatic test_q1_q3();
        push_tag(2'd1);
        push_tag(2'd3);
        @(negedge clk);
        res_valid = 1'b1; res_x = 16'h4000; res_y = 16'h2000;
        @(negedge clk);
        checks++; if ({out_valid, out_x, out_y, out_quadrant} !== {1'b1, 16'hE000, 16'h4000, 2'd1}) begin errors++; $display("FAIL q1_out got v%b %h %h q%0d want v1 e000 4000 q1", out_valid, out_x, out_y, out_quadrant); end
        @(negedge clk);
        res_valid = 1'b0;
        checks++; if ({out_valid, out_x, out_y, out_quadrant} !== {1'b1, 16'h2000, 16'hC000, 2'd3}) begin errors++; $display("FAIL q3_out got v%b %h %h q%0d want v1 2000 c000 q3", out_valid, out_x, out_y, out_quadrant); end
    endtask

    task automatic test_saturation();
        push_tag(2'd2);
        @(negedge clk);
        res_valid = 1'b1; res_x = 16'h8000; res_y = 16'h0001;
        @(negedge clk);
        res_valid = 1'b0;
        checks++; if ({out_valid, out_x, out_y} !== {1'b1, 16'h7FFF, 16'hFFFF}) begin errors++; $display("FAIL q2_sat got v%b %h %h want v1 7fff ffff", out_valid, out_x, out_y); end
    endtask

    task automatic test_backpressure();
        push_tag(2'd0); push_tag(2'd0); push_tag(2'd0);
        @(negedge clk);
        out_ready = 1'b1; res_valid = 1'b1; res_x = 16'h0100; res_y = 16'h0200;
        @(negedge clk);
        out_ready = 1'b0; res_x = 16'h0300; res_y = 16'h0400;
        #1;
        checks++; if (res_ready !== 1'b0) begin errors++; $display("FAIL bp_res_ready got %b want 0", res_ready); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if ({out_valid, out_x, out_y} !== {1'b1, 16'h0100, 16'h0200}) begin errors++; $display("FAIL bp_hold%0d got v%b %h %h want v1 0100 0200", i, out_valid, out_x, out_y); end
            checks++; if (tag_count !== 4'd2 || res_ready !== 1'b0) begin errors++; $display("FAIL bp_stall%0d got count %0d rdy %b want 2 0", i, tag_count, res_ready); end
        end
        out_ready = 1'b1;
        @(negedge clk);
        res_x = 16'h0500; res_y = 16'h0600;
        checks++; if ({out_valid, out_x, out_y, tag_count} !== {1'b1, 16'h0300, 16'h0400, 4'd1}) begin errors++; $display("FAIL bp_second got v%b %h %h c%0d want v1 0300 0400 c1", out_valid, out_x, out_y, tag_count); end
        @(negedge clk);
        res_valid = 1'b0;
        checks++; if ({out_valid, out_x, out_y, tag_count} !== {1'b1, 16'h0500, 16'h0600, 4'd0}) begin errors++; $display("FAIL bp_third got v%b %h %h c%0d want v1 0500 0600 c0", out_valid, out_x, out_y, tag_count); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_end_valid got %b want 0", out_valid); end
    endtask

    task automatic test_fifo();
        logic [1:0] exp_q [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3, 2'd1};
        res_x = 16'h1000; res_y = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            tag_valid = 1'b1; tag_quadrant = 2'(i);
        end
        @(negedge clk);
        checks++; if (tag_count !== 4'd8 || tag_ready !== 1'b0) begin errors++; $display("FAIL fifo_full got count %0d rdy %b want 8 0", tag_count, tag_ready); end
        tag_quadrant = 2'd2;
        @(negedge clk);
        tag_valid = 1'b0;
        checks++; if (tag_count !== 4'd8) begin errors++; $display("FAIL fifo_overpush got %0d want 8", tag_count); end
        res_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (out_quadrant !== exp_q[i]) begin errors++; $display("FAIL fifo_order%0d got %0d want %0d", i, out_quadrant, exp_q[i]); end
        end
        checks++; if (tag_count !== 4'd4) begin errors++; $display("FAIL fifo_count4 got %0d want 4", tag_count); end
        tag_valid = 1'b1; tag_quadrant = 2'd1;
        @(negedge clk);
        tag_valid = 1'b0;
        checks++; if (tag_count !== 4'd4 || out_quadrant !== 2'd0) begin errors++; $display("FAIL fifo_pushpop got count %0d q%0d want 4 q0", tag_count, out_quadrant); end
        for (int i = 4; i < 8; i++) begin
            @(negedge clk);
            checks++; if (out_quadrant !== exp_q[i]) begin errors++; $display("FAIL fifo_order%0d got %0d want %0d", i, out_quadrant, exp_q[i]); end
        end
        checks++; if (tag_count !== 4'd0) begin errors++; $display("FAIL fifo_drained got %0d want 0", tag_count); end
        repeat (2) begin
            @(negedge clk);
            checks++; if (res_ready !== 1'b0) begin errors++; $display("FAIL empty_res_ready got %b want 0", res_ready); end
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL empty_no_out got %b want 0", out_valid); end
        tag_valid = 1'b1; tag_quadrant = 2'd2;
        #1;
        checks++; if (res_ready !== 1'b0) begin errors++; $display("FAIL empty_no_bypass got %b want 0", res_ready); end
        @(negedge clk);
        tag_valid = 1'b0;
        checks++; if (res_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL empty_arrive got rdy %b v%b want 1 0", res_ready, out_valid); end
        @(negedge clk);
        res_valid = 1'b0;
        checks++; if ({out_valid, out_x, out_y, out_quadrant} !== {1'b1, 16'hF000, 16'h0000, 2'd2}) begin errors++; $display("FAIL empty_late got v%b %h %h q%0d want v1 f000 0000 q2", out_valid, out_x, out_y, out_quadrant); end
    endtask

    task automatic test_reset_mid();
        push_tag(2'd1); push_tag(2'd1); push_tag(2'd1); push_tag(2'd1);
        @(negedge clk);
        out_ready = 1'b0; res_valid = 1'b1; res_x = 16'h0001; res_y = 16'h0001;
        @(negedge clk);
        res_valid = 1'b0;
        checks++; if (tag_count !== 4'd3 || out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre got count %0d v%b want 3 1", tag_count, out_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (tag_count !== 4'd0 || out_valid !== 1'b0 || tag_ready !== 1'b1) begin errors++; $display("FAIL mid_async got count %0d v%b rdy %b want 0 0 1", tag_count, out_valid, tag_ready); end
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
    endtask

`ifdef CORDIC_GAIN_COMP_EN
    task automatic test_gain();
        push_tag(2'd0);
        @(negedge clk);
        res_valid = 1'b1; res_x = 16'h7FFF; res_y = 16'h0000;
        @(negedge clk);
        res_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL gain_early got %b want 0", out_valid); end
        @(negedge clk);
        checks++; if ({out_valid, out_x, out_y} !== {1'b1, 16'h4DBA, 16'h0000}) begin errors++; $display("FAIL gain_out got v%b %h %h want v1 4dba 0000", out_valid, out_x, out_y); end
    endtask
`endif

    initial begin
        test_reset();
`ifdef CORDIC_GAIN_COMP_EN
        test_gain();
`else
        test_q0();
        test_q1_q3();
        test_saturation();
        test_backpressure();
        test_fifo();
        test_reset_mid();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
